// File: rtl/pic_cfg_pkg.sv
// Shared types and constants for the cascaded 8259 PIC configuration controller.
package pic_cfg_pkg;

  typedef enum logic [1:0] {
    TOP_IDLE,
    TOP_RUN,
    TOP_DONE
  } top_state_t;

  typedef enum logic [2:0] {
    WC_IDLE,
    WC_SETUP,
    WC_STROBE,
    WC_HOLD,
    WC_RECOVER
  } wc_state_t;

  typedef enum logic [2:0] {
    W_ICW1,
    W_ICW2,
    W_ICW3,
    W_ICW4,
    W_OCW1,
    W_OCW3
  } word_t;

  localparam logic [7:0] ICW1_BASE   = 8'h11;
  localparam logic [7:0] ICW4_MASTER = 8'h00;
  localparam logic [7:0] ICW4_SLAVE  = 8'h02;
  localparam logic [7:0] OCW3_RD_ISR = 8'h0B;

  // ICW1 and OCW3 go to the even register address; every other word to the odd one.
  function automatic logic word_a0(input word_t w);
    return !(w == W_ICW1 || w == W_OCW3);
  endfunction

endpackage

// File: rtl/pic_bus_write_cycle.sv
// Timing of one register write: SETUP, WR_LOW strobe cycles, HOLD, RECOVER.
module pic_bus_write_cycle
  import pic_cfg_pkg::*;
#(
  parameter int N_CHIPS = 7,
  parameter int WR_LOW  = 2,
  parameter int CHIP_W  = $clog2(N_CHIPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [CHIP_W-1:0]  chip,
  input  logic               a0_in,
  input  logic [7:0]         data_in,
  output logic [N_CHIPS-1:0] chip_select,
  output logic               write_flag,
  output logic               a0,
  output logic [7:0]         data_out,
  output logic               data_oe,
  output logic               idle,
  output logic               done
);

  localparam int CNT_W = (WR_LOW > 1) ? $clog2(WR_LOW) : 1;

  wc_state_t        state;
  logic [CNT_W-1:0] low_cnt;

  assign idle = (state == WC_IDLE);
  assign done = (state == WC_RECOVER);

  // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= WC_IDLE;
      low_cnt     <= '0;
      chip_select <= '1;
      write_flag  <= 1'b1;
      a0          <= 1'b1;
      data_out    <= '0;
      data_oe     <= 1'b0;
    end else begin
      case (state)
        WC_IDLE, WC_RECOVER: begin
          if (go) begin
            state       <= WC_SETUP;
            chip_select <= ~(N_CHIPS'(1) << chip);
            a0          <= a0_in;
            data_out    <= data_in;
            data_oe     <= 1'b1;
          end else begin
            state <= WC_IDLE;
          end
        end
        WC_SETUP: begin
          state      <= WC_STROBE;
          write_flag <= 1'b0;
          low_cnt    <= CNT_W'(WR_LOW - 1);
        end
        WC_STROBE: begin
          if (low_cnt == '0) begin
            state      <= WC_HOLD;
            write_flag <= 1'b1;
          end else begin
            low_cnt <= low_cnt - CNT_W'(1);
          end
        end
        WC_HOLD: begin
          state       <= WC_RECOVER;
          chip_select <= '1;
          data_oe     <= 1'b0;
        end
        default: state <= WC_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pic_cascade_config_ctrl.sv
// Sequences ICW1..ICW4, OCW1 and optional OCW3 into a master 8259 and its present slaves.
module pic_cascade_config_ctrl
  import pic_cfg_pkg::*;
#(
  parameter int N_SLAVES = 6,
  parameter int WR_LOW   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N_SLAVES-1:0] slave_present,
  input  logic [4:0]          vector_base,
  input  logic [N_SLAVES:0]   ltim_mask,
  input  logic [7:0]          imr_init,
  input  logic                ocw3_en,
  output logic [N_SLAVES:0]   chip_select,
  output logic                write_flag,
  output logic                A0,
  output logic [7:0]          data_out,
  output logic                data_oe,
  output logic [N_SLAVES:0]   sp,
  output logic                busy,
  output logic                done
);

  localparam int N_CHIPS = N_SLAVES + 1;
  localparam int CHIP_W  = $clog2(N_CHIPS);

  top_state_t          state;
  logic [CHIP_W-1:0]   chip;
  logic [CHIP_W-1:0]   next_chip;
  word_t               word;
  word_t               last_word;
  logic                next_found;
  logic                all_issued;
  logic                go;
  logic                wc_idle;
  logic                wc_done;
  logic                wr_a0;
  logic [7:0]          wr_data;
  logic [4:0]          chip_vec;

  logic [N_SLAVES-1:0] snap_present;
  logic [4:0]          snap_vb;
  logic [N_SLAVES:0]   snap_ltim;
  logic [7:0]          snap_imr;
  logic                snap_ocw3;

  assign sp        = {{N_SLAVES{1'b0}}, 1'b1};
  assign last_word = snap_ocw3 ? W_OCW3 : W_OCW1;
  assign go        = (state == TOP_RUN) && (wc_idle || wc_done) && !all_issued;
  assign chip_vec  = snap_vb + 5'(chip);

  // Lowest present slave above the current chip; scanning downward lets the lowest win.
  always_comb begin
    next_chip  = '0;
    next_found = 1'b0;
    for (int k = N_SLAVES; k >= 1; k--) begin
      if (snap_present[k-1] && (k > int'(chip))) begin
        next_chip  = CHIP_W'(k);
        next_found = 1'b1;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    wr_a0   = word_a0(word);
    wr_data = '0;
    case (word)
      W_ICW1: wr_data = ICW1_BASE | {4'b0000, snap_ltim[chip], 3'b000};
      W_ICW2: wr_data = {chip_vec, 3'b000};
      W_ICW3: wr_data = (chip == '0) ? 8'(snap_present) : (8'(chip) - 8'd1);
      W_ICW4: wr_data = (chip == '0) ? ICW4_MASTER : ICW4_SLAVE;
      W_OCW1: wr_data = snap_imr;
      W_OCW3: wr_data = OCW3_RD_ISR;
      default: wr_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= TOP_IDLE;
      chip         <= '0;
      word         <= W_ICW1;
      all_issued   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      snap_present <= '0;
      snap_vb      <= '0;
      snap_ltim    <= '0;
      snap_imr     <= '0;
      snap_ocw3    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        TOP_IDLE: begin
          if (start) begin
            snap_present <= slave_present;
            snap_vb      <= vector_base;
            snap_ltim    <= ltim_mask;
            snap_imr     <= imr_init;
            snap_ocw3    <= ocw3_en;
            chip         <= '0;
            word         <= W_ICW1;
            all_issued   <= 1'b0;
            busy         <= 1'b1;
            state        <= TOP_RUN;
          end
        end
        TOP_RUN: begin
          // Counters always name the next word to hand to the write-cycle engine.
          if (go) begin
            if (word == last_word) begin
              if (next_found) begin
                chip <= next_chip;
                word <= W_ICW1;
              end else begin
                all_issued <= 1'b1;
              end
            end else begin
              word <= word_t'(word + 3'd1);
            end
          end else if ((wc_idle || wc_done) && all_issued) begin
            state <= TOP_DONE;
            done  <= 1'b1;
          end
        end
        TOP_DONE: begin
          state <= TOP_IDLE;
          busy  <= 1'b0;
        end
        default: state <= TOP_IDLE;
      endcase
    end
  end

  pic_bus_write_cycle #(
    .N_CHIPS (N_CHIPS),
    .WR_LOW  (WR_LOW),
    .CHIP_W  (CHIP_W)
  ) u_write_cycle (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (go),
    .chip        (chip),
    .a0_in       (wr_a0),
    .data_in     (wr_data),
    .chip_select (chip_select),
    .write_flag  (write_flag),
    .a0          (A0),
    .data_out    (data_out),
    .data_oe     (data_oe),
    .idle        (wc_idle),
    .done        (wc_done)
  );

endmodule

// File: tb/tb_pic_cascade_config_ctrl.sv
// Directed bench for pic_cascade_config_ctrl: word streams, latencies, snapshot and reset abort.
module tb_pic_cascade_config_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] slave_present = '0;
  logic [4:0] vector_base = '0;
  logic [6:0] ltim_mask = '0;
  logic [7:0] imr_init = '0;
  logic       ocw3_en = 1'b0;
  logic [6:0] chip_select;
  logic       write_flag;
  logic       A0;
  logic [7:0] data_out;
  logic       data_oe;
  logic [6:0] sp;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [6:0] log_cs   [512];
  logic       log_a0   [512];
  logic [7:0] log_data [512];
  int         log_n = 0;
  int         inv_bad = 0;
  logic       prev_wf = 1'b1;
  logic       mon_en = 1'b0;

  logic [6:0] exp_cs   [64];
  logic       exp_a0   [64];
  logic [7:0] exp_data [64];
  int         exp_n = 0;

  pic_cascade_config_ctrl #(.N_SLAVES(6), .WR_LOW(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .slave_present (slave_present),
    .vector_base   (vector_base),
    .ltim_mask     (ltim_mask),
    .imr_init      (imr_init),
    .ocw3_en       (ocw3_en),
    .chip_select   (chip_select),
    .write_flag    (write_flag),
    .A0            (A0),
    .data_out      (data_out),
    .data_oe       (data_oe),
    .sp            (sp),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: logs each word at the falling edge of write_flag and counts protocol breaches.
  always @(negedge clk) begin
    if (mon_en) begin
      prev_wf <= write_flag;
      if (write_flag === 1'b0 && prev_wf === 1'b1 && log_n < 512) begin
        log_cs[log_n]   <= chip_select;
        log_a0[log_n]   <= A0;
        log_data[log_n] <= data_out;
        log_n           <= log_n + 1;
      end
      if ($countones(~chip_select) > 1) inv_bad <= inv_bad + 1;
      else if (write_flag !== 1'b1 && chip_select === 7'h7F) inv_bad <= inv_bad + 1;
      else if (chip_select !== 7'h7F && data_oe !== 1'b1) inv_bad <= inv_bad + 1;
      else if (sp !== 7'b0000001) inv_bad <= inv_bad + 1;
    end
  end

  task automatic set_cfg(input logic [5:0] pres, input logic [4:0] vb, input logic [6:0] ltim,
                         input logic [7:0] imr, input logic o3);
    slave_present = pres;
    vector_base   = vb;
    ltim_mask     = ltim;
    imr_init      = imr;
    ocw3_en       = o3;
  endtask

  // Reference word list derived from the register definitions of the 8259 cascade.
  task automatic build_expected(input logic [5:0] pres, input logic [4:0] vb, input logic [6:0] ltim,
                                input logic [7:0] imr, input logic o3);
    logic [4:0] vv;
    exp_n = 0;
    for (int c = 0; c <= 6; c++) begin
      if (c == 0 || pres[c-1]) begin
        for (int w = 0; w < (o3 ? 6 : 5); w++) begin
          exp_cs[exp_n] = 7'h7F;
          exp_cs[exp_n][c] = 1'b0;
          exp_a0[exp_n] = 1'b1;
          case (w)
            0: begin
              exp_data[exp_n] = ltim[c] ? 8'h19 : 8'h11;
              exp_a0[exp_n]   = 1'b0;
            end
            1: begin
              vv = vb + 5'(c);
              exp_data[exp_n] = {vv, 3'b000};
            end
            2: exp_data[exp_n] = (c == 0) ? {2'b00, pres} : 8'(c - 1);
            3: exp_data[exp_n] = (c == 0) ? 8'h00 : 8'h02;
            4: exp_data[exp_n] = imr;
            default: begin
              exp_data[exp_n] = 8'h0B;
              exp_a0[exp_n]   = 1'b0;
            end
          endcase
          exp_n++;
        end
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string name, input int exp_lat, output logic [6:0] low_seen);
    bit found = 0;
    int lat = -1;
    low_seen = '0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      low_seen = low_seen | ~chip_select;
      if (done === 1'b1) begin
        found = 1;
        lat   = cyc - start_cyc;
        break;
      end
    end
    checks++;
    if (!found || lat != exp_lat) begin
      $display("FAIL %s latency: got %0d (found=%0d), expected %0d", name, lat, found, exp_lat);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL %s post-done: done=%b busy=%b, expected done=0 busy=0", name, done, busy);
      errors++;
    end
  endtask

  task automatic compare_log(input string name, input int base);
    checks++;
    if (log_n - base != exp_n) begin
      $display("FAIL %s word count: got %0d, expected %0d", name, log_n - base, exp_n);
      errors++;
    end
    for (int i = 0; i < exp_n && base + i < log_n; i++) begin
      checks++;
      if (log_cs[base+i] !== exp_cs[i] || log_a0[base+i] !== exp_a0[i] || log_data[base+i] !== exp_data[i]) begin
        $display("FAIL %s word %0d: got cs=%b a0=%b data=%h, expected cs=%b a0=%b data=%h", name, i,
                 log_cs[base+i], log_a0[base+i], log_data[base+i], exp_cs[i], exp_a0[i], exp_data[i]);
        errors++;
      end
    end
    checks++;
    if (inv_bad != 0) begin
      $display("FAIL %s bus protocol: got %0d violations, expected 0", name, inv_bad);
      errors++;
    end
  endtask

  task automatic run_seq(input string name, input int exp_lat, output int base, output logic [6:0] low_seen);
    base = log_n;
    pulse_start();
    wait_done(name, exp_lat, low_seen);
    #1;
    compare_log(name, base);
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (chip_select !== 7'h7F || write_flag !== 1'b1 || A0 !== 1'b1 || data_out !== 8'h00 ||
        data_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL %s: got cs=%b wf=%b a0=%b data=%h oe=%b busy=%b done=%b, expected 1111111 1 1 00 0 0 0",
               name, chip_select, write_flag, A0, data_out, data_oe, busy, done);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    checks++;
    if (sp !== 7'b0000001) begin
      $display("FAIL reset_sp: got %b, expected 0000001", sp);
      errors++;
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("idle_no_start");
  endtask

  task automatic test_full_cascade();
    int base;
    logic [6:0] ls;
    logic [7:0] m_exp [5] = '{8'h11, 8'h08, 8'h3F, 8'h00, 8'h00};
    logic [7:0] s_exp [5] = '{8'h11, 8'h18, 8'h01, 8'h02, 8'h00};
    set_cfg(6'b111111, 5'd1, 7'h00, 8'h00, 1'b0);
    build_expected(6'b111111, 5'd1, 7'h00, 8'h00, 1'b0);
    run_seq("full_cascade", 176, base, ls);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_data[base+i] !== m_exp[i] || log_data[base+10+i] !== s_exp[i]) begin
        $display("FAIL full_cascade hand word %0d: got master=%h slave2=%h, expected %h %h",
                 i, log_data[base+i], log_data[base+10+i], m_exp[i], s_exp[i]);
        errors++;
      end
    end
  endtask

  task automatic test_ltim_ocw3();
    int base;
    logic [6:0] ls;
    set_cfg(6'b111111, 5'd1, 7'b0100000, 8'h00, 1'b1);
    build_expected(6'b111111, 5'd1, 7'b0100000, 8'h00, 1'b1);
    run_seq("ltim_ocw3", 211, base, ls);
    checks++;
    if (log_data[base+30] !== 8'h19 || log_a0[base+30] !== 1'b0) begin
      $display("FAIL slave5_icw1: got a0=%b data=%h, expected a0=0 data=19", log_a0[base+30], log_data[base+30]);
      errors++;
    end
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (log_data[base+c*6+5] !== 8'h0B || log_a0[base+c*6+5] !== 1'b0) begin
        $display("FAIL ocw3 chip %0d: got a0=%b data=%h, expected a0=0 data=0b",
                 c, log_a0[base+c*6+5], log_data[base+c*6+5]);
        errors++;
      end
    end
  endtask

  task automatic test_sparse();
    int base;
    logic [6:0] ls;
    set_cfg(6'b000101, 5'd1, 7'h00, 8'hA5, 1'b0);
    build_expected(6'b000101, 5'd1, 7'h00, 8'hA5, 1'b0);
    run_seq("sparse", 76, base, ls);
    checks++;
    if (ls !== 7'b0001011) begin
      $display("FAIL sparse selects: got low mask %b, expected 0001011", ls);
      errors++;
    end
    checks++;
    if (log_data[base+2] !== 8'h05) begin
      $display("FAIL sparse master_icw3: got %h, expected 05", log_data[base+2]);
      errors++;
    end
  endtask

  task automatic test_restart_ignored();
    int base;
    int n;
    logic [6:0] ls;
    set_cfg(6'b111111, 5'd1, 7'h00, 8'h00, 1'b0);
    build_expected(6'b111111, 5'd1, 7'h00, 8'h00, 1'b0);
    base = log_n;
    pulse_start();
    repeat (39) @(negedge clk);
    start = 1'b1;
    set_cfg(6'b000001, 5'd20, 7'h7F, 8'hFF, 1'b1);
    @(negedge clk) start = 1'b0;
    wait_done("restart_ignored", 176, ls);
    #1;
    compare_log("restart_ignored", base);
    n = log_n;
    repeat (20) @(negedge clk);
    checks++;
    if (log_n != n || busy !== 1'b0) begin
      $display("FAIL restart_no_rerun: got %0d extra words busy=%b, expected 0 and 0", log_n - n, busy);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int n;
    bit hit = 0;
    logic [6:0] ls;
    set_cfg(6'b111111, 5'd1, 7'h00, 8'h00, 1'b0);
    build_expected(6'b111111, 5'd1, 7'h00, 8'h00, 1'b0);
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (chip_select === 7'b1110111 && write_flag === 1'b0) begin
        hit = 1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      $display("FAIL reset_mid: slave3 strobe not seen, expected within 400 cycles");
      errors++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_mid_abort");
    rst_n = 1'b1;
    n = log_n;
    repeat (20) @(negedge clk);
    checks++;
    if (log_n != n || busy !== 1'b0) begin
      $display("FAIL reset_mid quiet: got %0d strobes busy=%b, expected 0 and 0", log_n - n, busy);
      errors++;
    end
    run_seq("reset_mid_rerun", 176, base, ls);
  endtask

  initial begin
    test_reset();
    test_full_cascade();
    test_ltim_ocw3();
    test_sparse();
    test_restart_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
